multi_channel_pulse_shaper: RTL
===============================

Name: multi_channel_pulse_shaper

Overview:
- N-channel successor to the single-channel pulse shaper, sitting between the photon-detector input pins and the time-correlation counters in the 500 MHz clk domain.
- Each channel synchronises its asynchronous detector input and detects rising edges.
- Each accepted edge produces one clean pulse of programmable width, followed by a programmable dead time.
- Edges arriving during pulse/dead time are counted as dropped, so pile-up losses can be corrected in software.

Parameters:
N_CH, 4, number of independent channels
CNT_W, 8, width of pulse-width/dead-time config and per-channel timer
SYNC_STAGES, 2, synchroniser flops per channel input (legal range 2..4)
DROP_W, 16, width of each per-channel dropped-edge counter

Ports:
clk  in  1  system clock, 500 MHz
rst_n  in  1  asynchronous active-low reset
channel  in  N_CH  asynchronous detector inputs, one bit per channel
enable  in  1  synchronous global arm; 0 = ignore new edges
pulse_width  in  CNT_W  pulse high time in clk cycles; 0 treated as 1
dead_time  in  CNT_W  minimum clk cycles between accepted pulse rising edges; 0 treated as 1
clear_stats  in  1  synchronous clear of all drop counters
pulse  out  N_CH  shaped output pulses, registered
busy  out  N_CH  1 while channel is in PULSE or DEAD
drop_cnt  out  N_CH*DROP_W  packed saturating dropped-edge counters, channel i at [i*DROP_W +: DROP_W]

Behaviour:
Reset (rst_n low, async):
- Sync chains, edge-detect delay flop, timers and drop counters = 0.
- All channels in IDLE; pulse = 0, busy = 0, drop_cnt = 0.
- Reset mid-pulse aborts immediately: pulse falls asynchronously.

Front end, per channel:
- channel[i] passes through SYNC_STAGES flops to s, then one delay flop to s_d.
- edge = s & ~s_d, combinational.
- A channel held high through reset release yields exactly one edge.

Latency:
- Counting the first clk edge that samples channel[i] high as edge 1, pulse[i] is high after clk edge SYNC_STAGES+1.
- Default: 3 edges, 6 ns.

Per-channel FSM (IDLE, PULSE, DEAD):
- IDLE: edge & enable -> PULSE.
  - Latch Weff = max(pulse_width,1).
  - Latch Peff = max(max(dead_time,1), Weff+1).
  - timer = 0; pulse = 1; busy = 1.
- PULSE: timer increments each cycle.
  - When timer == Weff-1, next cycle pulse = 0 and state -> DEAD.
- DEAD: timer continues.
  - When timer == Peff-1, next cycle state -> IDLE and busy = 0.
  - An edge in that same IDLE cycle is accepted.
  - Net effect: consecutive pulse rising edges are at least Peff cycles apart, and there is always at least 1 low cycle between pulses.
- Config changes take effect only at the next trigger, never mid-pulse.

Enable:
- Deassertion does not truncate an in-progress pulse or dead time.
- Edges seen while enable = 0 are ignored and are not counted as drops.

Drop counting:
- An edge with enable = 1 while in PULSE or DEAD increments drop_cnt[i].
- Counters saturate at 2^DROP_W-1 and never wrap.
- clear_stats sets all counters to 0; when clear_stats and a drop occur in the same cycle, clear wins (result 0).

Channel independence:
- Channels are fully independent; simultaneous edges on all channels each produce a pulse in the same cycle.

Test Plan:
1. Latency and width: W=1, D=30, single rising edge on ch0 -> pulse[0] high exactly 1 cycle, rising after edge 3; busy[0] high 30 cycles; other channels idle.
2. Dead time and drops: W=1, D=30, ch0 edges at t=0, 10, 20, 31 cycles -> pulses rising at 3 and 34; drop_cnt[0]=2.
3. Degenerate config: W=0, D=0 -> 1-cycle pulse, Peff=2. W=5, D=3 -> pulse 5 cycles high; next pulse rises no earlier than 6 cycles after the previous rise, leaving a 1-cycle low gap.
4. Enable and mid-pulse config change: W=10, D=20. Drop enable and change W to 2 three cycles into the pulse -> the 10-cycle pulse completes; edges with enable=0 give no pulse and no drop. Re-enable and trigger -> 2-cycle pulse.
5. Saturation and clear: DROP_W=4; force 20 drops -> drop_cnt=15. Assert clear_stats in the same cycle as a drop -> drop_cnt=0.
6. Async reset mid-pulse: W=20, assert rst_n low at cycle 5 of the pulse -> pulse, busy and drop_cnt are 0 without waiting for a clk edge. Channel held high across release -> exactly one pulse.

Source files
------------

// File: rtl/multi_channel_pulse_shaper_if.sv
// multi_channel_pulse_shaper_if: detector inputs, shaping config and per-channel outputs
interface multi_channel_pulse_shaper_if #(
  parameter int N_CH = 4,
  parameter int CNT_W = 8,
  parameter int DROP_W = 16
);
  logic [N_CH-1:0] channel;
  logic enable;
  logic [CNT_W-1:0] pulse_width;
  logic [CNT_W-1:0] dead_time;
  logic clear_stats;
  logic [N_CH-1:0] pulse;
  logic [N_CH-1:0] busy;
  logic [N_CH*DROP_W-1:0] drop_cnt;
  modport master (
    output channel, enable, pulse_width, dead_time, clear_stats,
    input pulse, busy, drop_cnt
  );
  modport slave (
    input channel, enable, pulse_width, dead_time, clear_stats,
    output pulse, busy, drop_cnt
  );
endinterface

// File: rtl/multi_channel_pulse_shaper.sv
// multi_channel_pulse_shaper: per-channel sync, edge detect, shaped pulse plus dead time, saturating drop counters
module multi_channel_pulse_shaper #(
  parameter int N_CH = 4,
  parameter int CNT_W = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DROP_W = 16
) (
  input logic clk,
  input logic rst_n,
  multi_channel_pulse_shaper_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PULSE, DEAD} state_t;
  logic [CNT_W-1:0] w_in, d_in;
  logic [CNT_W:0] w_plus, p_in;
  logic [N_CH-1:0] pulse_v, busy_v;
  logic [N_CH*DROP_W-1:0] drop_v;
  assign w_in = bus.pulse_width == '0 ? CNT_W'(1) : bus.pulse_width;
  assign d_in = bus.dead_time == '0 ? CNT_W'(1) : bus.dead_time;
  assign w_plus = {1'b0, w_in} + (CNT_W+1)'(1);
  // period is stretched past the width so pulses never merge
  assign p_in = {1'b0, d_in} > w_plus ? {1'b0, d_in} : w_plus;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t state;
    logic [SYNC_STAGES-1:0] sync;
    logic s_d, hit, pulse_q, busy_q;
    logic [CNT_W-1:0] timer, weff;
    logic [CNT_W:0] peff;
    logic [DROP_W-1:0] drops;
    assign hit = sync[SYNC_STAGES-1] & ~s_d & bus.enable;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync <= '0;
        s_d <= 1'b0;
        state <= IDLE;
        timer <= '0;
        weff <= CNT_W'(1);
        peff <= (CNT_W+1)'(2);
        pulse_q <= 1'b0;
        busy_q <= 1'b0;
        drops <= '0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], bus.channel[i]};
        s_d <= sync[SYNC_STAGES-1];
        drops <= bus.clear_stats ? '0 :
                 (hit && state != IDLE && drops != '1) ? drops + DROP_W'(1) : drops;
        case (state)
          IDLE: if (hit) begin
            state <= PULSE;
            weff <= w_in;
            peff <= p_in;
            timer <= '0;
            pulse_q <= 1'b1;
            busy_q <= 1'b1;
          end
          PULSE: begin
            timer <= timer + CNT_W'(1);
            if (timer == weff - CNT_W'(1)) begin
              pulse_q <= 1'b0;
              state <= DEAD;
            end
          end
          DEAD: begin
            timer <= timer + CNT_W'(1);
            if ({1'b0, timer} == peff - (CNT_W+1)'(1)) begin
              busy_q <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
    assign pulse_v[i] = pulse_q;
    assign busy_v[i] = busy_q;
    assign drop_v[i*DROP_W +: DROP_W] = drops;
  end
  assign bus.pulse = pulse_v;
  assign bus.busy = busy_v;
  assign bus.drop_cnt = drop_v;
endmodule
